// File: rtl/map_rom_arbiter.sv
// ---------------------------------------------------------------------------
// map_rom_arbiter
//
// Shares the single-port maze map ROM between the VGA renderer and the
// game-logic collision checker. One ROM read is issued per cycle. Ownership
// of each read is tracked through the ROM's one-cycle registered latency, and
// the data is returned to the owner together with a one-cycle valid pulse.
// VGA has priority. The collision checker is forced a grant after STARVE_MAX
// consecutive VGA grants while it is waiting.
//
// Optional feature (macro MAP_ROM_ARB_STATS_EN):
//   defined     -> col_stall_cnt_o is a saturating 16-bit count of edges where
//                  col_req_i was high but collision was not granted.
//   not defined -> col_stall_cnt_o is tied to 0.
//
// Ports:
//   clk_i            system clock
//   rst_ni           asynchronous active-low reset
//   vga_req_i        VGA read request
//   vga_addr_i       VGA row address
//   vga_gnt_o        one-cycle grant pulse to VGA
//   vga_valid_o      one-cycle pulse, vga_data_o updated
//   vga_data_o       VGA read data, held between valids
//   col_req_i        collision read request
//   col_addr_i       collision row address
//   col_gnt_o        one-cycle grant pulse to collision
//   col_valid_o      one-cycle pulse, col_data_o updated
//   col_data_o       collision read data, held between valids
//   rom_addr_o       address to the ROM
//   rom_data_i       ROM data, valid one cycle after rom_addr_o is sampled
//   busy_o           high while any read is in flight
//   col_stall_cnt_o  collision stall statistics
// ---------------------------------------------------------------------------
module map_rom_arbiter #(
    parameter int ADDRW      = 5,
    parameter int DATAW      = 30,
    parameter int DEPTH      = 21,
    parameter int STARVE_MAX = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             vga_req_i,
    input  logic [ADDRW-1:0] vga_addr_i,
    output logic             vga_gnt_o,
    output logic             vga_valid_o,
    output logic [DATAW-1:0] vga_data_o,
    input  logic             col_req_i,
    input  logic [ADDRW-1:0] col_addr_i,
    output logic             col_gnt_o,
    output logic             col_valid_o,
    output logic [DATAW-1:0] col_data_o,
    output logic [ADDRW-1:0] rom_addr_o,
    input  logic [DATAW-1:0] rom_data_i,
    output logic             busy_o,
    output logic [15:0]      col_stall_cnt_o
);

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    // Arbitration decision on the currently sampled requests
    logic             grant_vga;
    logic             grant_col;
    logic [ADDRW-1:0] sel_addr;
    logic             sel_oor;
    logic [3:0]       starve_q, starve_d;

    // Ownership pipeline: stage 1 = address presented to ROM,
    // stage 2 = ROM data arrives at the next edge
    logic             s1_vld_q, s1_col_q, s1_oor_q;
    logic             s2_vld_q, s2_col_q, s2_oor_q;

    logic [ADDRW-1:0] rom_addr_q;
    logic             vga_gnt_q, col_gnt_q;
    logic             vga_valid_q, col_valid_q;
    logic [DATAW-1:0] vga_data_q, col_data_q;
    logic [DATAW-1:0] ret_data;

    always_comb begin
        // VGA wins unless the collision checker has waited STARVE_MAX grants
        grant_vga = vga_req_i && !(col_req_i && (starve_q == STARVE_LIM));
        grant_col = col_req_i && !grant_vga;
        sel_addr  = grant_vga ? vga_addr_i : col_addr_i;
        sel_oor   = (int'(sel_addr) >= DEPTH);

        starve_d  = starve_q;
        if (grant_col || !col_req_i) begin
            starve_d = 4'd0;
        end else if (grant_vga) begin
            // col_req_i is high here, so this is a VGA grant over a waiting collision
            starve_d = starve_q + 4'd1;
        end
    end

    // Rows outside the maze read back as solid wall
    assign ret_data = s2_oor_q ? {DATAW{1'b1}} : rom_data_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            starve_q    <= '0;
            rom_addr_q  <= '0;
            vga_gnt_q   <= 1'b0;
            col_gnt_q   <= 1'b0;
            s1_vld_q    <= 1'b0;
            s1_col_q    <= 1'b0;
            s1_oor_q    <= 1'b0;
            s2_vld_q    <= 1'b0;
            s2_col_q    <= 1'b0;
            s2_oor_q    <= 1'b0;
            vga_valid_q <= 1'b0;
            col_valid_q <= 1'b0;
            vga_data_q  <= '0;
            col_data_q  <= '0;
        end else begin
            starve_q  <= starve_d;
            vga_gnt_q <= grant_vga;
            col_gnt_q <= grant_col;

            // rom_addr holds when nobody is granted
            if (grant_vga || grant_col) begin
                rom_addr_q <= sel_oor ? '0 : sel_addr;
            end

            s1_vld_q <= grant_vga || grant_col;
            s1_col_q <= grant_col;
            s1_oor_q <= sel_oor;

            s2_vld_q <= s1_vld_q;
            s2_col_q <= s1_col_q;
            s2_oor_q <= s1_oor_q;

            vga_valid_q <= s2_vld_q && !s2_col_q;
            col_valid_q <= s2_vld_q &&  s2_col_q;
            if (s2_vld_q && !s2_col_q) begin
                vga_data_q <= ret_data;
            end
            if (s2_vld_q && s2_col_q) begin
                col_data_q <= ret_data;
            end
        end
    end

    assign rom_addr_o  = rom_addr_q;
    assign vga_gnt_o   = vga_gnt_q;
    assign col_gnt_o   = col_gnt_q;
    assign vga_valid_o = vga_valid_q;
    assign col_valid_o = col_valid_q;
    assign vga_data_o  = vga_data_q;
    assign col_data_o  = col_data_q;
    assign busy_o      = s1_vld_q || s2_vld_q;

`ifdef MAP_ROM_ARB_STATS_EN
    logic [15:0] stall_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_q <= '0;
        end else if (col_req_i && !grant_col && (stall_q != 16'hFFFF)) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign col_stall_cnt_o = stall_q;
`else
    assign col_stall_cnt_o = 16'd0;
`endif

endmodule
